// File: rtl/calc_pkg.sv
// Shared types for the calculator datapath: entry-sequencer states and the
// status-LED phase encoding.
package calc_pkg;

    typedef enum logic [2:0] {
        ENTER_A  = 3'd0,
        ENTER_B  = 3'd1,
        ENTER_OP = 3'd2,
        EXEC     = 3'd3,
        SHOW     = 3'd4
    } entry_state_t;

    localparam logic [1:0] PHASE_A    = 2'd0;
    localparam logic [1:0] PHASE_B    = 2'd1;
    localparam logic [1:0] PHASE_OP   = 2'd2;
    localparam logic [1:0] PHASE_SHOW = 2'd3;

    // EXEC and SHOW share the SHOW phase on the LEDs.
    function automatic logic [1:0] phase_of(input entry_state_t s);
        logic [1:0] p;
        case (s)
            ENTER_A:  p = PHASE_A;
            ENTER_B:  p = PHASE_B;
            ENTER_OP: p = PHASE_OP;
            EXEC:     p = PHASE_SHOW;
            SHOW:     p = PHASE_SHOW;
            default:  p = PHASE_A;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser, stability counter and rising-edge detector for one
// bouncy push-button; press fires on the same edge the level is accepted.
module button_debouncer #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] COUNT_MAX = CW'(DEB_CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic          press_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_s;
    logic          level_s;
    logic          press_s;

    // Count consecutive samples that disagree with the accepted level.
    always_comb begin
        count_s = count_r;
        level_s = level_r;
        press_s = 1'b0;
        if (sync2_r == level_r) begin
            count_s = {CW{1'b0}};
        end else if (count_r == COUNT_MAX) begin
            level_s = sync2_r;
            count_s = {CW{1'b0}};
            press_s = sync2_r;
        end else begin
            count_s = count_r + CW'(1'b1);
        end
    end

    // Synchroniser and debounce state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            press_r <= 1'b0;
            count_r <= {CW{1'b0}};
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            level_r <= level_s;
            press_r <= press_s;
            count_r <= count_s;
        end
    end

    assign level = level_r;
    assign press = press_r;

endmodule

// File: rtl/operand_entry_fsm.sv
// Operand entry sequencer: captures A, B and the operation select from the
// board switches on successive debounced presses, then pulses exec once.
module operand_entry_fsm
    import calc_pkg::*;
#(
    parameter int M          = 6,
    parameter int DEB_CYCLES = 500000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [M-1:0] sw,
    input  logic [3:0]   op_sw,
    input  logic         btn_next,
    input  logic         btn_clear,
    output logic [M-1:0] a,
    output logic [M-1:0] b,
    output logic [3:0]   sel,
    output logic         exec,
    output logic [1:0]   phase
);

    logic [M-1:0] sw_sync1_r;
    logic [M-1:0] sw_sync2_r;
    logic [3:0]   op_sync1_r;
    logic [3:0]   op_sync2_r;

    logic         next_level_s;
    logic         next_press_s;
    logic         clear_level_s;
    logic         clear_press_s;
    logic         next_go_s;
    logic         clear_go_s;

    entry_state_t state_r;
    entry_state_t state_s;
    logic [M-1:0] a_r, a_s;
    logic [M-1:0] b_r, b_s;
    logic [3:0]   sel_r, sel_s;
    logic         exec_r, exec_s;
    logic [1:0]   phase_r, phase_s;

    button_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_next (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_next),
        .level (next_level_s),
        .press (next_press_s)
    );

    button_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_clear (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_clear),
        .level (clear_level_s),
        .press (clear_press_s)
    );

    // A press always coincides with its accepted level going high.
    assign next_go_s  = next_press_s && next_level_s;
    assign clear_go_s = clear_press_s && clear_level_s;

    // Operand and operation switch synchronisers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_sync1_r <= {M{1'b0}};
            sw_sync2_r <= {M{1'b0}};
            op_sync1_r <= 4'd0;
            op_sync2_r <= 4'd0;
        end else begin
            sw_sync1_r <= sw;
            sw_sync2_r <= sw_sync1_r;
            op_sync1_r <= op_sw;
            op_sync2_r <= op_sync1_r;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ENTER_A;
            a_r     <= {M{1'b0}};
            b_r     <= {M{1'b0}};
            sel_r   <= 4'd0;
            exec_r  <= 1'b0;
            phase_r <= PHASE_A;
        end else begin
            state_r <= state_s;
            a_r     <= a_s;
            b_r     <= b_s;
            sel_r   <= sel_s;
            exec_r  <= exec_s;
            phase_r <= phase_s;
        end
    end

    // Next-state logic; clear overrides next in every state, EXEC never waits.
    always_comb begin
        state_s = state_r;
        if (clear_go_s) begin
            state_s = ENTER_A;
        end else begin
            case (state_r)
                ENTER_A:  if (next_go_s) state_s = ENTER_B;  else state_s = ENTER_A;
                ENTER_B:  if (next_go_s) state_s = ENTER_OP; else state_s = ENTER_B;
                ENTER_OP: if (next_go_s) state_s = EXEC;     else state_s = ENTER_OP;
                EXEC:     state_s = SHOW;
                SHOW:     if (next_go_s) state_s = ENTER_A;  else state_s = SHOW;
                default:  state_s = ENTER_A;
            endcase
        end
    end

    // Output next values, decoded from the next state so exec lines up with EXEC.
    always_comb begin
        a_s     = a_r;
        b_s     = b_r;
        sel_s   = sel_r;
        exec_s  = (state_s == EXEC);
        phase_s = phase_of(state_s);
        if (clear_go_s) begin
            a_s   = {M{1'b0}};
            b_s   = {M{1'b0}};
            sel_s = 4'd0;
        end else begin
            case (state_r)
                ENTER_A:  if (next_go_s) a_s   = sw_sync2_r; else a_s   = a_r;
                ENTER_B:  if (next_go_s) b_s   = sw_sync2_r; else b_s   = b_r;
                ENTER_OP: if (next_go_s) sel_s = op_sync2_r; else sel_s = sel_r;
                default:  a_s = a_r;
            endcase
        end
    end

    assign a     = a_r;
    assign b     = b_r;
    assign sel   = sel_r;
    assign exec  = exec_r;
    assign phase = phase_r;

endmodule

// File: tb/tb_operand_entry_fsm.sv
// Directed bench for operand_entry_fsm with a short debounce window.
module tb_operand_entry_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] sw;
    logic [3:0] op_sw;
    logic       btn_next;
    logic       btn_clear;
    logic [5:0] a;
    logic [5:0] b;
    logic [3:0] sel;
    logic       exec;
    logic [1:0] phase;

    int n_cmp = 0;
    int n_bad = 0;
    int exec_cnt = 0;
    int exec_b2b = 0;
    int exec_bad_phase = 0;
    logic exec_prev = 1'b0;

    operand_entry_fsm #(.M(6), .DEB_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .op_sw     (op_sw),
        .btn_next  (btn_next),
        .btn_clear (btn_clear),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .exec      (exec),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    // exec pulse bookkeeping, sampled away from the active edge.
    always @(negedge clk) begin
        if (exec) begin
            exec_cnt <= exec_cnt + 1;
            if (exec_prev) exec_b2b <= exec_b2b + 1;
            if (phase != 2'd3) exec_bad_phase <= exec_bad_phase + 1;
        end
        exec_prev <= exec;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_next();
        btn_next = 1'b1;
        tick(10);
        btn_next = 1'b0;
        tick(10);
    endtask

    // Third press: exec must be high on the first cycle phase shows 3, low after.
    task automatic press_exec(input string tag);
        int k;
        k = 0;
        btn_next = 1'b1;
        while (phase != 2'd3 && k < 30) begin
            tick(1);
            k++;
        end
        check_eq({tag, "_phase_show"}, 32'(phase), 32'd3);
        check_eq({tag, "_exec_on_entry"}, 32'(exec), 32'd1);
        tick(1);
        check_eq({tag, "_exec_drops"}, 32'(exec), 32'd0);
        check_eq({tag, "_phase_hold"}, 32'(phase), 32'd3);
        btn_next = 1'b0;
        tick(10);
    endtask

    initial begin
        int e0;
        rst = 1'b1;
        sw = 6'd0;
        op_sw = 4'd0;
        btn_next = 1'b0;
        btn_clear = 1'b0;
        tick(3);
        rst = 1'b0;

        // Reset then idle
        tick(50);
        check_eq("idle_a", 32'(a), 32'd0);
        check_eq("idle_b", 32'(b), 32'd0);
        check_eq("idle_sel", 32'(sel), 32'd0);
        check_eq("idle_phase", 32'(phase), 32'd0);
        check_eq("idle_exec_cnt", 32'(exec_cnt), 32'd0);

        // Full entry
        sw = 6'b000101;
        press_next();
        check_eq("full_phase_b", 32'(phase), 32'd1);
        check_eq("full_a_cap", 32'(a), 32'd5);
        sw = 6'b111101;
        press_next();
        check_eq("full_phase_op", 32'(phase), 32'd2);
        check_eq("full_b_cap", 32'(b), 32'd61);
        op_sw = 4'b0010;
        e0 = exec_cnt;
        press_exec("full");
        check_eq("full_a", 32'(a), 32'd5);
        check_eq("full_b", 32'(b), 32'd61);
        check_eq("full_sel", 32'(sel), 32'd2);
        check_eq("full_exec_count", 32'(exec_cnt - e0), 32'd1);

        // Re-entry from SHOW keeps operands
        sw = 6'd0;
        op_sw = 4'd0;
        press_next();
        check_eq("reent_phase", 32'(phase), 32'd0);
        check_eq("reent_a", 32'(a), 32'd5);
        check_eq("reent_b", 32'(b), 32'd61);
        check_eq("reent_sel", 32'(sel), 32'd2);

        // Bounce: toggle, then settle high; advance on the 7th edge after settling
        sw = 6'd63;
        btn_next = 1'b1;
        tick(1);
        btn_next = 1'b0;
        tick(1);
        btn_next = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick(1);
            if (i == 6) check_eq("bounce_before", 32'(phase), 32'd0);
            if (i == 7) check_eq("bounce_at", 32'(phase), 32'd1);
        end
        tick(20);
        check_eq("bounce_single", 32'(phase), 32'd1);
        check_eq("bounce_a", 32'(a), 32'd63);
        btn_next = 1'b0;
        tick(10);

        // Asynchronous reset between edges in ENTER_B
        #2 rst = 1'b1;
        #1;
        check_eq("arst_a", 32'(a), 32'd0);
        check_eq("arst_sel", 32'(sel), 32'd0);
        check_eq("arst_phase", 32'(phase), 32'd0);
        tick(2);
        rst = 1'b0;
        tick(5);

        // Second full sequence
        sw = 6'd63;
        press_next();
        sw = 6'd0;
        press_next();
        op_sw = 4'hF;
        e0 = exec_cnt;
        press_exec("second");
        check_eq("second_a", 32'(a), 32'd63);
        check_eq("second_b", 32'(b), 32'd0);
        check_eq("second_sel", 32'(sel), 32'd15);
        check_eq("second_exec_count", 32'(exec_cnt - e0), 32'd1);

        // Clear priority over a simultaneous next in ENTER_OP
        press_next();
        sw = 6'd5;
        press_next();
        sw = 6'd61;
        press_next();
        check_eq("clr_pre_phase", 32'(phase), 32'd2);
        check_eq("clr_pre_b", 32'(b), 32'd61);
        e0 = exec_cnt;
        btn_next = 1'b1;
        btn_clear = 1'b1;
        tick(10);
        check_eq("clr_phase", 32'(phase), 32'd0);
        check_eq("clr_a", 32'(a), 32'd0);
        check_eq("clr_b", 32'(b), 32'd0);
        check_eq("clr_sel", 32'(sel), 32'd0);
        btn_next = 1'b0;
        btn_clear = 1'b0;
        tick(10);
        check_eq("clr_no_exec", 32'(exec_cnt - e0), 32'd0);
        check_eq("clr_phase_after", 32'(phase), 32'd0);

        check_eq("exec_back_to_back", 32'(exec_b2b), 32'd0);
        check_eq("exec_outside_show", 32'(exec_bad_phase), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
